mem_wb_skid_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.
//  in_ready is registered, so SRAM back-pressure does not form a combinational path into MEM.
//  The write-back value (load data or ALU result) is selected at capture; only the selected value is stored.

---
 rtl/mem_wb_skid_stage.sv | 131 +++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage with a registered in_ready and a two-entry skid buffer.
// The write-back value is selected when an entry is captured; the stage also counts stalled cycles.
//
// state | meaning
// EMPTY | no entry held, outputs idle
// BUSY  | MAIN holds the head entry, SKID empty
// FULL  | MAIN and SKID both hold entries, in_ready low
module mem_wb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic [DATA_W-1:0] out_wb_value,
  output logic [DEST_W-1:0] out_dest,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t            state;
  logic              skid_wb_en;
  logic [DATA_W-1:0] skid_value;
  logic [DEST_W-1:0] skid_dest;
  logic [CTRL_W-1:0] skid_ctrl;

  logic              accept;
  logic              drain;
  logic [DATA_W-1:0] sel;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;
  assign sel    = in_mem_r_en ? in_mem_data : in_alu_res;

  // The MAIN entry is the output register set itself; out_wb_en is cleared whenever MAIN empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_wb_en    <= 1'b0;
      out_wb_value <= '0;
      out_dest     <= '0;
      out_ctrl     <= '0;
      skid_wb_en   <= 1'b0;
      skid_value   <= '0;
      skid_dest    <= '0;
      skid_ctrl    <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_wb_en  <= 1'b0;
      skid_wb_en <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state        <= BUSY;
            out_valid    <= 1'b1;
            out_wb_en    <= in_wb_en;
            out_wb_value <= sel;
            out_dest     <= in_dest;
            out_ctrl     <= in_ctrl;
          end
        end
        BUSY: begin
          if (accept && !drain) begin
            state      <= FULL;
            in_ready   <= 1'b0;
            skid_wb_en <= in_wb_en;
            skid_value <= sel;
            skid_dest  <= in_dest;
            skid_ctrl  <= in_ctrl;
          end else if (accept && drain) begin
            out_wb_en    <= in_wb_en;
            out_wb_value <= sel;
            out_dest     <= in_dest;
            out_ctrl     <= in_ctrl;
          end else if (drain) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_wb_en <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            state        <= BUSY;
            in_ready     <= 1'b1;
            out_wb_en    <= skid_wb_en;
            out_wb_value <= skid_value;
            out_dest     <= skid_dest;
            out_ctrl     <= skid_ctrl;
            skid_wb_en   <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_wb_en <= 1'b0;
        end
      endcase
    end
  end

  // Stalls are counted even in flush cycles; only rst clears the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, random traffic and a CNT_W=2 instance.
module tb_mem_wb_skid_stage;

  typedef struct {
    logic        wb_en;
    logic [31:0] value;
    logic [3:0]  dest;
    logic [1:0]  ctrl;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wb_en = 1'b0;
  logic        in_mem_r_en = 1'b0;
  logic [31:0] in_alu_res = '0;
  logic [31:0] in_mem_data = '0;
  logic [3:0]  in_dest = '0;
  logic [1:0]  in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_wb_en;
  logic [31:0] out_wb_value;
  logic [3:0]  out_dest;
  logic [1:0]  out_ctrl;
  logic [15:0] stall_cnt;

  logic        s_in_valid = 1'b0;
  logic        s_out_ready = 1'b0;
  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_out_wb_en;
  logic [31:0] s_out_wb_value;
  logic [3:0]  s_out_dest;
  logic [1:0]  s_out_ctrl;
  logic [1:0]  s_stall_cnt;

  int tests  = 0;
  int errors = 0;

  ent_t q[$];
  int   model_cnt = 0;

  always #5 clk = ~clk;

  mem_wb_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
    .in_mem_r_en(in_mem_r_en), .in_alu_res(in_alu_res), .in_mem_data(in_mem_data),
    .in_dest(in_dest), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
    .out_wb_value(out_wb_value), .out_dest(out_dest), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  mem_wb_skid_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_wb_en(1'b1),
    .in_mem_r_en(1'b0), .in_alu_res(32'h0000_00A5), .in_mem_data(32'h0000_005A),
    .in_dest(4'h9), .in_ctrl(2'h2),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_wb_en(s_out_wb_en),
    .out_wb_value(s_out_wb_value), .out_dest(s_out_dest), .out_ctrl(s_out_ctrl),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries; ready means fewer than two are held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      model_cnt = 0;
    end else begin
      automatic bit ready = (q.size() < 2);
      automatic bit acc   = in_valid && ready;
      automatic bit drn   = (q.size() > 0) && out_ready;
      automatic ent_t e;
      if (in_valid && !ready && model_cnt < 65535) model_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          e.wb_en = in_wb_en;
          e.value = in_mem_r_en ? in_mem_data : in_alu_res;
          e.dest  = in_dest;
          e.ctrl  = in_ctrl;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("m_stall_cnt", 64'(stall_cnt), 64'(model_cnt));
      if (q.size() > 0) begin
        check("m_wb_value", 64'(out_wb_value), 64'(q[0].value));
        check("m_dest", 64'(out_dest), 64'(q[0].dest));
        check("m_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
        check("m_wb_en", 64'(out_wb_en), 64'(q[0].wb_en));
      end else begin
        check("m_wb_en_idle", 64'(out_wb_en), 64'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic wb, input logic mr, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [3:0] d, input logic [1:0] c);
    in_valid    = v;
    in_wb_en    = wb;
    in_mem_r_en = mr;
    in_alu_res  = alu;
    in_mem_data = mem;
    in_dest     = d;
    in_ctrl     = c;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_wb_en", 64'(out_wb_en), 64'd0);
    check("rst_wb_value", 64'(out_wb_value), 64'd0);
    check("rst_dest", 64'(out_dest), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_sat_stall", 64'(s_stall_cnt), 64'd0);
    s_in_valid = 1'b1;

    // First entry: ALU result, one-cycle latency
    out_ready = 1'b1;
    drive(1, 1, 0, 32'h11, 32'h99, 4'd3, 2'd1);
    step();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_value", 64'(out_wb_value), 64'h11);
    check("t1_dest", 64'(out_dest), 64'd3);
    check("t1_wb_en", 64'(out_wb_en), 64'd1);

    // Load data selected
    drive(1, 1, 1, 32'h5, 32'hDEADBEEF, 4'd7, 2'd2);
    step();
    check("t2_value", 64'(out_wb_value), 64'hDEADBEEF);
    in_valid = 1'b0;
    step();
    check("t2_empty", 64'(out_valid), 64'd0);

    // A, B, C with out_ready low
    out_ready = 1'b0;
    drive(1, 1, 0, 32'd1, 32'd0, 4'd1, 2'd0);
    step();
    drive(1, 1, 0, 32'd2, 32'd0, 4'd2, 2'd0);
    step();
    check("abc_ready_low", 64'(in_ready), 64'd0);
    drive(1, 1, 0, 32'd3, 32'd0, 4'd3, 2'd0);
    repeat (3) step();
    check("abc_stall3", 64'(stall_cnt), 64'd3);
    check("abc_head_a", 64'(out_wb_value), 64'd1);
    out_ready = 1'b1;
    step();
    check("abc_head_b", 64'(out_wb_value), 64'd2);
    check("abc_ready_back", 64'(in_ready), 64'd1);
    step();
    check("abc_head_c", 64'(out_wb_value), 64'd3);
    in_valid = 1'b0;
    step();
    check("abc_drained", 64'(out_valid), 64'd0);
    check("abc_stall4", 64'(stall_cnt), 64'd4);

    // Flush while FULL with a new entry offered
    out_ready = 1'b0;
    drive(1, 1, 0, 32'hAA, 32'd0, 4'd5, 2'd0);
    step();
    drive(1, 1, 0, 32'hBB, 32'd0, 4'd6, 2'd0);
    step();
    check("fl_full", 64'(in_ready), 64'd0);
    drive(1, 1, 0, 32'h77, 32'd0, 4'd7, 2'd0);
    flush = 1'b1;
    step();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_wb_en", 64'(out_wb_en), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("fl_stays_empty", 64'(out_valid), 64'd0);
    check("fl_stall5", 64'(stall_cnt), 64'd5);

    // Streaming 100 entries back to back
    for (int i = 0; i < 100; i++) begin
      drive(1, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom), 2'($urandom));
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_stall", 64'(stall_cnt), 64'd5);

    // Random traffic with back-pressure and occasional flush
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
            4'($urandom), 2'($urandom));
      out_ready = 1'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Async reset while FULL
    out_ready = 1'b0;
    drive(1, 1, 0, 32'h42, 32'd0, 4'd2, 2'd1);
    repeat (4) step();
    check("rs_full", 64'(in_ready), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid_async", 64'(out_valid), 64'd0);
    check("rs_stall_async", 64'(stall_cnt), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    step();
    check("rs_ready_after", 64'(in_ready), 64'd1);
    check("rs_empty_after", 64'(out_valid), 64'd0);

    // Saturating counter on the CNT_W=2 instance
    repeat (8) step();
    check("sat_stall", 64'(s_stall_cnt), 64'd3);
    check("sat_valid", 64'(s_out_valid), 64'd1);
    check("sat_ready", 64'(s_in_ready), 64'd0);
    check("sat_value", 64'(s_out_wb_value), 64'hA5);
    check("sat_fields", 64'({s_out_wb_en, s_out_dest, s_out_ctrl}), 64'({1'b1, 4'h9, 2'h2}));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
